// File: rtl/shift_rows_stream_if.sv
// Byte-stream interface for the ShiftRows engine.
// Carries both the upstream handshake (in_byte/in_valid/in_ready/in_mode)
// and the downstream handshake (out_byte/out_valid/out_ready/out_last),
// plus the busy status flag.
//   master : the environment side (drives input stream, accepts output)
//   slave  : the engine side
interface shift_rows_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    output in_byte, in_valid, in_mode, out_ready,
    input  in_ready, out_byte, out_valid, out_last, busy
  );

  modport slave (
    input  in_byte, in_valid, in_mode, out_ready,
    output in_ready, out_byte, out_valid, out_last, busy
  );
endinterface

// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows / InvShiftRows engine with ping-pong banks.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of shift_rows_stream_if (input stream with per-block
//          mode, permuted output stream with last flag, busy status)
// Parameters: NB (4, 6 or 8 columns), DATA_W (symbol width).
module shift_rows_stream #(
  parameter int unsigned NB     = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  shift_rows_stream_if.slave bus
);
  localparam int unsigned S     = 4 * NB;
  localparam int unsigned CNT_W = $clog2(S);
  localparam int unsigned COL_W = $clog2(NB);
  localparam logic [COL_W:0]   NBW   = (COL_W+1)'(NB);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(S - 1);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  // Row shift amount; NB=8 uses the wider 0,1,3,4 offsets
  function automatic logic [COL_W:0] f_shift(input logic [1:0] row);
    case (row)
      2'd0:    f_shift = '0;
      2'd1:    f_shift = (COL_W+1)'(1);
      2'd2:    f_shift = (NB == 8) ? (COL_W+1)'(3) : (COL_W+1)'(2);
      default: f_shift = (NB == 8) ? (COL_W+1)'(4) : (COL_W+1)'(3);
    endcase
  endfunction

  logic [DATA_W-1:0] r_mem [2][S];
  logic [1:0]        r_full;
  logic [1:0]        r_mode;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [DATA_W-1:0] r_out_byte;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_in_ready;
  logic              r_busy;

  logic              w_wr_fire;
  logic              w_rd_fire;
  logic [1:0]        w_full_nxt;
  logic              w_wr_ptr_nxt;
  logic              w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_wr_cnt_nxt;
  logic [CNT_W-1:0]  w_rd_cnt_nxt;
  logic [1:0]        w_row;
  logic [COL_W:0]    w_col;
  logic [COL_W:0]    w_sh;
  logic [COL_W:0]    w_src;
  logic [CNT_W-1:0]  w_rd_addr;

  assign w_wr_fire = bus.in_valid && r_in_ready;
  assign w_rd_fire = r_out_valid && bus.out_ready;

  // Next pointer/counter/bank-state; write and read never target the same bank
  always_comb begin
    w_full_nxt   = r_full;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    if (w_wr_fire) begin
      if (r_wr_cnt == LAST) begin
        w_full_nxt[r_wr_ptr] = 1'b1;
        w_wr_ptr_nxt         = ~r_wr_ptr;
        w_wr_cnt_nxt         = '0;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
      end
    end
    if (w_rd_fire) begin
      if (r_rd_cnt == LAST) begin
        w_full_nxt[r_rd_ptr] = 1'b0;
        w_rd_ptr_nxt         = ~r_rd_ptr;
        w_rd_cnt_nxt         = '0;
      end else begin
        w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
      end
    end
  end

  // Source address for the next output index; wraps by compare/add, no multiply
  always_comb begin
    w_row = w_rd_cnt_nxt[1:0];
    w_col = (COL_W+1)'(w_rd_cnt_nxt[CNT_W-1:2]);
    w_sh  = f_shift(w_row);
    if (r_mode[w_rd_ptr_nxt]) begin
      w_src = (w_col < w_sh) ? (w_col + NBW - w_sh) : (w_col - w_sh);
    end else begin
      w_src = ((w_col + w_sh) >= NBW) ? (w_col + w_sh - NBW) : (w_col + w_sh);
    end
    w_rd_addr = {w_src[COL_W-1:0], w_row};
  end

  // Bank storage; contents are don't-care until the bank is FULL
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr][r_wr_cnt] <= bus.in_byte;
    end
  end

  // Control state and registered outputs (look-ahead read of the next entry)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= '0;
      r_mode      <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_wr_fire && (r_wr_cnt == '0)) begin
        r_mode[r_wr_ptr] <= bus.in_mode;
      end
      r_full      <= w_full_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      if (w_full_nxt[w_rd_ptr_nxt]) begin
        r_out_byte <= r_mem[w_rd_ptr_nxt][w_rd_addr];
      end
      r_out_valid <= w_full_nxt[w_rd_ptr_nxt];
      r_out_last  <= w_full_nxt[w_rd_ptr_nxt] && (w_rd_cnt_nxt == LAST);
      r_in_ready  <= ~w_full_nxt[w_wr_ptr_nxt];
      r_busy      <= (|w_full_nxt) || (w_wr_cnt_nxt != '0);
    end
  end

  assign bus.out_byte  = r_out_byte;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: NB=4 and NB=8 instances,
// random blocks/modes/gaps/back-pressure against a formula-based model.
module tb_shift_rows_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_rows_stream_if #(.DATA_W(8)) if4 ();
  shift_rows_stream_if #(.DATA_W(8)) if8 ();

  shift_rows_stream #(.NB(4), .DATA_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  shift_rows_stream #(.NB(8), .DATA_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: output index k = r + 4c takes in[r + 4*((c +/- shift(r)) mod nb)]
  function automatic int sh_of(int nb, int r);
    if (r < 2) return r;
    return (nb == 8) ? r + 1 : r;
  endfunction

  function automatic int src_idx(int nb, int mode, int k);
    int r, c, s;
    r = k % 4;
    c = k / 4;
    s = (mode != 0) ? c - sh_of(nb, r) : c + sh_of(nb, r);
    s = ((s % nb) + nb) % nb;
    return r + 4 * s;
  endfunction

  logic [8:0] exp_q[$];
  bit hold_rdy = 0;
  bit rand_rdy = 0;
  bit no_drop  = 0;
  int n_acc = 0, n_xfer = 0, first_cyc = 0, last_cyc = 0, cyc = 0;

  // Drives nbytes of a block into the NB=4 instance; optionally queues expected output
  task automatic send4(input logic [7:0] blk[16], input logic mode, input int nbytes,
                       input bit push, input int gap);
    if (push) begin
      for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, blk[src_idx(4, int'(mode), k)]});
    end
    for (int i = 0; i < nbytes; i++) begin
      int t = 0;
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        @(negedge clk);
        if4.in_valid = 1'b0;
      end
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.in_byte  = blk[i];
      if4.in_mode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
      while (!if4.in_ready && t < 300) begin
        if (no_drop) check("in_ready_drop", 32'(if4.in_ready), 32'd1);
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        check("in_timeout", 32'(t), 32'd0);
        break;
      end
      n_acc++;
    end
  endtask

  task automatic idle4();
    @(negedge clk);
    if4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic rand_blk(output logic [7:0] b[16]);
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
  endtask

  // Output monitor / sink for the NB=4 instance
  initial begin
    logic [7:0] sb;
    logic       sl;
    logic       sv;
    logic [8:0] e;
    sv = 1'b0;
    sb = '0;
    sl = 1'b0;
    if4.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sv = 1'b0;
      end else begin
        if4.out_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        if (sv) begin
          check("stall_byte", 32'(if4.out_byte), 32'(sb));
          check("stall_last", 32'(if4.out_last), 32'(sl));
          check("stall_valid", 32'(if4.out_valid), 32'd1);
        end
        if (if4.out_valid && if4.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(if4.out_byte), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 32'(if4.out_byte), 32'(e[7:0]));
            check("out_last", 32'(if4.out_last), 32'(e[8]));
          end
          n_xfer++;
          if (n_xfer == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
        sv = if4.out_valid && !if4.out_ready;
        sb = if4.out_byte;
        sl = if4.out_last;
      end
    end
  end

  // One NB=8 block: drive 32 bytes while collecting and checking outputs
  task automatic run8(input logic [7:0] b[32], input logic mode, input bit spot);
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          int t = 0;
          @(negedge clk);
          if8.in_valid = 1'b1;
          if8.in_byte  = b[i];
          if8.in_mode  = (i == 0) ? mode : ~mode;
          while (!if8.in_ready && t < 200) begin
            @(negedge clk);
            t++;
          end
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
      end
      begin
        int got = 0;
        int t = 0;
        while (got < 32 && t < 300) begin
          @(negedge clk);
          t++;
          if (if8.out_valid && if8.out_ready) begin
            check("nb8_byte", 32'(if8.out_byte), 32'(b[src_idx(8, int'(mode), got)]));
            check("nb8_last", 32'(if8.out_last), 32'(got == 31));
            if (spot && got == 3)  check("nb8_r3c0", 32'(if8.out_byte), 32'h13);
            if (spot && got == 30) check("nb8_r2c7", 32'(if8.out_byte), 32'h0A);
            got++;
          end
        end
        if (got < 32) check("nb8_timeout", 32'(got), 32'd32);
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0[16];
    logic [7:0] b1[16];
    logic [7:0] b2[16];
    logic [7:0] b8[32];
    if4.in_valid = 1'b0; if4.in_byte = '0; if4.in_mode = 1'b0;
    if8.in_valid = 1'b0; if8.in_byte = '0; if8.in_mode = 1'b0; if8.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst4_valid", 32'(if4.out_valid), 32'd0);
    check("rst4_last",  32'(if4.out_last),  32'd0);
    check("rst4_byte",  32'(if4.out_byte),  32'd0);
    check("rst4_busy",  32'(if4.busy),      32'd0);
    check("rst4_ready", 32'(if4.in_ready),  32'd1);
    check("rst8_valid", 32'(if8.out_valid), 32'd0);
    check("rst8_busy",  32'(if8.busy),      32'd0);
    check("rst8_ready", 32'(if8.in_ready),  32'd1);

    // Counting block, mode 0, with latency check on the last byte
    for (int i = 0; i < 16; i++) b0[i] = 8'(i);
    send4(b0, 1'b0, 16, 1'b1, 0);
    check("lat_pre", 32'(if4.out_valid), 32'd0);
    @(negedge clk);
    if4.in_valid = 1'b0;
    check("lat_post", 32'(if4.out_valid), 32'd1);
    drain4();

    // Counting block, mode 1
    send4(b0, 1'b1, 16, 1'b1, 0);
    idle4();
    drain4();

    // Back-to-back blocks with different modes: no input stall, contiguous output
    rand_blk(b1);
    no_drop = 1;
    n_xfer  = 0;
    send4(b0, 1'b0, 16, 1'b1, 0);
    send4(b1, 1'b1, 16, 1'b1, 0);
    idle4();
    no_drop = 0;
    drain4();
    check("contig_n", 32'(n_xfer), 32'd32);
    check("contig_span", 32'(last_cyc - first_cyc), 32'd31);

    // Output held off while three blocks are offered
    for (int i = 0; i < 16; i++) begin
      b1[i] = 8'(16 + i);
      b2[i] = 8'(32 + i);
    end
    hold_rdy = 1;
    n_acc = 0;
    fork
      begin
        send4(b0, 1'b0, 16, 1'b1, 0);
        send4(b1, 1'b1, 16, 1'b1, 0);
        send4(b2, 1'b0, 16, 1'b1, 0);
        idle4();
      end
      begin
        repeat (40) @(negedge clk);
        check("bp_in_ready", 32'(if4.in_ready),  32'd0);
        check("bp_accepted", 32'(n_acc),         32'd32);
        check("bp_out_byte", 32'(if4.out_byte),  32'h00);
        check("bp_valid",    32'(if4.out_valid), 32'd1);
        check("bp_busy",     32'(if4.busy),      32'd1);
        hold_rdy = 0;
      end
    join
    drain4();
    check("bp_all_accepted", 32'(n_acc), 32'd48);

    // Random blocks, modes, input gaps and output back-pressure
    rand_rdy = 1;
    for (int n = 0; n < 6; n++) begin
      rand_blk(b1);
      send4(b1, 1'($urandom_range(0, 1)), 16, 1'b1, 30);
    end
    idle4();
    drain4();
    rand_rdy = 0;

    // Reset with a full bank pending and a partial block in flight
    rand_blk(b1);
    b1[0] = 8'hA5;
    hold_rdy = 1;
    send4(b1, 1'b0, 16, 1'b0, 0);
    rand_blk(b2);
    send4(b2, 1'b1, 7, 1'b0, 0);
    @(negedge clk);
    if4.in_valid = 1'b0;
    check("pre_rst_valid", 32'(if4.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(if4.out_valid), 32'd0);
    check("mid_rst_byte",  32'(if4.out_byte),  32'd0);
    check("mid_rst_busy",  32'(if4.busy),      32'd0);
    check("mid_rst_ready", 32'(if4.in_ready),  32'd1);
    check("mid_rst_last",  32'(if4.out_last),  32'd0);
    @(negedge clk);
    hold_rdy = 0;
    rst = 1'b0;
    rand_blk(b1);
    send4(b1, 1'b1, 16, 1'b1, 0);
    idle4();
    drain4();
    check("post_rst_busy", 32'(if4.busy), 32'd0);

    // NB=8: counting block mode 0 with spot checks, then a random mode-1 block
    for (int i = 0; i < 32; i++) b8[i] = 8'(i);
    run8(b8, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) b8[i] = 8'($urandom);
    run8(b8, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Byte-serial AES/Rijndael ShiftRows / InvShiftRows engine with its own controller and ready/valid handshakes on both sides.
- Input is a column-major state stream (byte index i = row + 4*col). Output is the same stream in row-shifted order.
- Sits between the SubBytes and MixColumns byte-serial stages in the AES datapath.
- Generalises the fixed Nb=4, externally sequenced permutation datapath to Nb = 4/6/8, adds a per-block encrypt/decrypt mode, and uses ping-pong buffering to sustain 1 byte/cycle.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value is a compile-time error.
- DATA_W, 8, symbol width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_byte  input  DATA_W  input symbol.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  block accepts in_byte this cycle.
- in_mode  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled only on a block's first accepted byte.
- out_byte  output  DATA_W  permuted symbol.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts out_byte.
- out_last  output  1  out_byte is the final byte (index 4*NB-1) of its block.
- busy  output  1  at least one bank is holding or receiving data.

Behaviour:
- Block size: S = 4*NB bytes. A transfer occurs when valid and ready are both high on a rising edge.
- Row shift offsets: NB=4 or 6 use 0,1,2,3; NB=8 uses 0,1,3,4.
- Permutation for output index r+4c:
  - Mode 0 emits in[r + 4*((c + sh[r]) mod NB)].
  - Mode 1 emits in[r + 4*((c - sh[r]) mod NB)].
  - The mod is a true wrap: (c - sh) < 0 adds NB.
- Storage: two banks (A, B) of S x DATA_W, each with a state FULL/EMPTY and a latched mode bit.
- Write side:
  - A write pointer selects the bank and a counter runs 0..S-1.
  - The first byte of a block latches in_mode into that bank.
  - On write count S-1, the bank is marked FULL, the pointer toggles, and the count returns to 0.
  - in_ready = (write bank EMPTY). in_ready is deasserted when both banks are FULL.
- Read side:
  - A read pointer and counter 0..S-1 walk the bank in output order.
  - Addresses come from the bank's latched mode; no multiplier.
  - out_valid = (read bank FULL).
  - On a read at count S-1, the bank is marked EMPTY, the pointer toggles, and the count returns to 0.
- Latency: the first output byte is valid the cycle after the block's last input byte is accepted.
- Throughput: 1 byte/cycle sustained when out_ready is held high.
- Stall: while out_valid && !out_ready, out_byte, out_last and the read counter hold stable.
- Simultaneous events:
  - A write completing into bank X while a read completes from bank Y on the same edge must update both state bits.
  - A bank cannot be written and read in the same cycle.
- Back-pressure: in_valid while in_ready is low has no effect. in_mode changes mid-block are ignored.
- Reset mid-block: all in-flight data is discarded. Pointers and counters go to 0 and both banks to EMPTY.
- Reset values: out_valid=0, out_last=0, out_byte=0, busy=0, in_ready=1 on the first edge after rst deasserts.
- busy is high if any bank is FULL or the write count is nonzero.
- out_byte is a registered read of the selected bank entry.

Test Plan:
- NB=4, mode 0, stream 0x00..0x0F with out_ready=1 -> output 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; out_last only on 0B; first out_valid 1 cycle after 0x0F accepted.
- NB=4, mode 1, same input -> 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
- NB=4, two back-to-back blocks (mode 0 then mode 1), out_ready=1, in_valid=1 -> in_ready never drops; 32 outputs contiguous; each block uses its own mode.
- out_ready=0 held for 40 cycles while 3 blocks are offered -> in_ready falls after byte 32; out_byte stays at 00 and stable; on release, the 32 bytes drain in order and in_ready rises.
- NB=8, mode 0, input 0x00..0x1F -> row3 of column 0 = in[3+4*4]=0x13, row2 of column 7 = in[2+4*2]=0x0A; full 32-byte sequence matches the reference model.
- Assert rst at input byte 7 of a block -> outputs go to reset values immediately; the next full block permutes correctly with no stale bytes.
